// File: rtl/adsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adsr_pkg
// Description : Shared definitions for the ADSR envelope stage: envelope
//               state encoding, unity-gain constant and the four fixed
//               instrument profiles (organ, piano, flute, pluck).
//               Profile constants are scaled for 12 envelope fraction bits.
// Revision    : 1.0 - initial release
// ============================================================================
package adsr_pkg;

  // Envelope fraction bits the profile tables are scaled for
  localparam int ENV_W_DEF = 12;

  // Exact unity gain
  localparam int FULL = 1 << ENV_W_DEF;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } adsr_state_e;

  // Linear per-sample steps and sustain target, indexed by instrument:
  //                                         organ  piano  flute  pluck
  localparam int unsigned ATK_STEP  [4] = '{ 4096,    64,     8,  4096 };
  localparam int unsigned DEC_STEP  [4] = '{    0,     2,     1,     4 };
  localparam int unsigned SUS_LEVEL [4] = '{ 4096,  1024,  3072,     0 };
  localparam int unsigned REL_STEP  [4] = '{ 4096,     4,    16,    64 };

  // Exponential-mode shifts; 0 means jump straight to the target level
  localparam int unsigned DEC_SHIFT [4] = '{    0,     9,    10,     8 };
  localparam int unsigned REL_SHIFT [4] = '{    0,     8,     6,     5 };

endpackage
`default_nettype wire

// File: rtl/adsr_gain_mult.sv
`default_nettype none
// ============================================================================
// Module      : adsr_gain_mult
// Description : Two-stage gain pipeline. Stage 1 captures the accepted
//               sample; stage 2 multiplies it (signed) by the envelope
//               level (unsigned) into a registered product. The output is
//               the product arithmetically shifted down by ENV_W (floor).
//               Latency from sample_valid to sample_out_valid is 2 cycles,
//               throughput one sample per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_gain_mult #(
  parameter int ENV_W    = 12,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic [ENV_W:0]      level,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid
);

  // Signed sample x unsigned (ENV_W+1)-bit level
  localparam int PROD_W = SAMPLE_W + ENV_W + 1;

  logic [SAMPLE_W-1:0]      sample_q, sample_d;
  logic                     stage1_vld_q, stage1_vld_d;
  logic signed [PROD_W-1:0] product_q, product_d;
  logic                     stage2_vld_q, stage2_vld_d;

  logic signed [PROD_W-1:0] w_sample_ext;
  logic signed [PROD_W-1:0] w_level_ext;
  logic signed [PROD_W-1:0] w_product;

  // Level is non-negative, so zero-extension keeps the multiply signed-correct
  assign w_sample_ext = {{(PROD_W - SAMPLE_W){sample_q[SAMPLE_W-1]}}, sample_q};
  assign w_level_ext  = {{(PROD_W - ENV_W - 1){1'b0}}, level};
  assign w_product    = w_sample_ext * w_level_ext;

  // Next-state for both pipeline stages; data registers hold between strobes
  always_comb begin
    sample_d     = sample_q;
    product_d    = product_q;
    stage1_vld_d = sample_valid;
    stage2_vld_d = stage1_vld_q;
    if (sample_valid) begin
      sample_d = sample_in;
    end
    if (stage1_vld_q) begin
      product_d = w_product;
    end
  end

  // Pipeline registers; reset drops anything in flight
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample_q     <= '0;
      stage1_vld_q <= 1'b0;
      product_q    <= '0;
      stage2_vld_q <= 1'b0;
    end else begin
      sample_q     <= sample_d;
      stage1_vld_q <= stage1_vld_d;
      product_q    <= product_d;
      stage2_vld_q <= stage2_vld_d;
    end
  end

  // Level never exceeds unity, so the shifted product always fits SAMPLE_W
  assign sample_out       = SAMPLE_W'(product_q >>> ENV_W);
  assign sample_out_valid = stage2_vld_q;

endmodule
`default_nettype wire

// File: rtl/adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : adsr_envelope
// Description : Attack/decay/sustain/release gain envelope applied to the
//               mixed chord sample stream. The envelope steps once per
//               accepted sample; note events change state immediately and
//               the level step on the same cycle uses the new state's rule.
//               Retrigger resumes attack from the current level.
//               Optional macro ADSR_EXP_DECAY_EN: exponential decay and
//               release steps (max(level >> shift, 1)); default is linear.
// Revision    : 1.0 - initial release
// ============================================================================
module adsr_envelope
  import adsr_pkg::*;
#(
  parameter int ENV_W    = 12,
  parameter int SAMPLE_W = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                note_start,
  input  logic                note_release,
  input  logic [1:0]          instrument,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                sample_out_valid,
  output logic                env_active,
  output logic                env_done,
  output logic [ENV_W:0]      env_level
);

  localparam int LVL_W = ENV_W + 1;
  localparam int CMP_W = ENV_W + 2;
  localparam logic [LVL_W-1:0] FULL_LVL = {1'b1, {ENV_W{1'b0}}};

  adsr_state_e      state_q, state_d;
  adsr_state_e      w_evt_state;
  logic [LVL_W-1:0] level_q, level_d;
  logic [1:0]       inst_q, inst_d;
  logic             done_q, done_d;

  logic [1:0]       w_inst;
  logic [LVL_W-1:0] w_atk;
  logic [LVL_W-1:0] w_sus;
  logic [LVL_W-1:0] w_dec_step;
  logic [LVL_W-1:0] w_rel_step;
  logic [CMP_W-1:0] w_atk_sum;
  logic [CMP_W-1:0] w_dec_floor;

`ifdef ADSR_EXP_DECAY_EN
  // Exponential step: shift 0 jumps to the target, otherwise at least 1
  function automatic logic [LVL_W-1:0] exp_step(input logic [LVL_W-1:0] lvl,
                                                input int unsigned      sh);
    logic [LVL_W-1:0] scaled;
    scaled = lvl >> sh;
    if (sh == 0) begin
      return lvl;
    end
    if (scaled == '0) begin
      return LVL_W'(1);
    end
    return scaled;
  endfunction
`endif

  // A note start latches the new profile; it governs this cycle's step too
  assign w_inst = note_start ? instrument : inst_q;

  // Profile constants and step arithmetic for the profile in force this cycle
  always_comb begin
    w_atk = LVL_W'(ATK_STEP[w_inst]);
    w_sus = LVL_W'(SUS_LEVEL[w_inst]);
`ifdef ADSR_EXP_DECAY_EN
    w_dec_step = exp_step(level_q, DEC_SHIFT[w_inst]);
    w_rel_step = exp_step(level_q, REL_SHIFT[w_inst]);
`else
    w_dec_step = LVL_W'(DEC_STEP[w_inst]);
    w_rel_step = LVL_W'(REL_STEP[w_inst]);
`endif
    w_atk_sum   = {1'b0, level_q} + {1'b0, w_atk};
    w_dec_floor = {1'b0, w_sus} + {1'b0, w_dec_step};
  end

  // Event handling first, then the level step under the resulting state
  always_comb begin
    w_evt_state = state_q;
    state_d     = state_q;
    level_d     = level_q;
    inst_d      = w_inst;
    done_d      = 1'b0;

    // note_start wins over a simultaneous note_release
    if (note_start) begin
      w_evt_state = ST_ATTACK;
    end else if (note_release &&
                 (state_q == ST_ATTACK || state_q == ST_DECAY ||
                  state_q == ST_SUSTAIN)) begin
      w_evt_state = ST_RELEASE;
    end
    state_d = w_evt_state;

    if (sample_valid) begin
      case (w_evt_state)
        ST_ATTACK: begin
          if (w_atk_sum >= CMP_W'(FULL_LVL)) begin
            level_d = FULL_LVL;
            state_d = ST_DECAY;
          end else begin
            level_d = w_atk_sum[LVL_W-1:0];
          end
        end
        ST_DECAY: begin
          if ({1'b0, level_q} > w_dec_floor) begin
            level_d = level_q - w_dec_step;
          end else begin
            level_d = w_sus;
          end
          // A zero decay step means the profile has no decay phase
          if (level_d == w_sus || w_dec_step == '0) begin
            state_d = ST_SUSTAIN;
          end
        end
        ST_RELEASE: begin
          if (level_q > w_rel_step) begin
            level_d = level_q - w_rel_step;
          end else begin
            level_d = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
        default: begin
          level_d = level_q;
        end
      endcase
    end
  end

  // Envelope state, level and latched profile
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      level_q <= '0;
      inst_q  <= 2'd0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
      inst_q  <= inst_d;
      done_q  <= done_d;
    end
  end

  // level_q holds the updated level during the multiply cycle
  adsr_gain_mult #(
    .ENV_W    (ENV_W),
    .SAMPLE_W (SAMPLE_W)
  ) u_gain_mult (
    .clk              (clk),
    .reset            (reset),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .level            (level_q),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid)
  );

  assign env_active = (state_q != ST_IDLE);
  assign env_done   = done_q;
  assign env_level  = level_q;

endmodule
`default_nettype wire

// File: tb/tb_adsr_envelope.sv
`default_nettype none
// ============================================================================
// Module      : tb_adsr_envelope
// Description : Self-checking bench for adsr_envelope. A behavioural model
//               tracks envelope phase, level and the expected output stream
//               using plain integer arithmetic on the profile rules.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adsr_envelope;

  localparam int ENV_W    = 12;
  localparam int SAMPLE_W = 16;
  localparam int FULL     = 4096;

  localparam int P_IDLE = 0, P_ATK = 1, P_DEC = 2, P_SUS = 3, P_REL = 4;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic [SAMPLE_W-1:0] sample_in = '0;
  logic                sample_valid = 1'b0;
  logic                note_start = 1'b0;
  logic                note_release = 1'b0;
  logic [1:0]          instrument = 2'd0;
  logic [SAMPLE_W-1:0] sample_out;
  logic                sample_out_valid;
  logic                env_active;
  logic                env_done;
  logic [ENV_W:0]      env_level;

  adsr_envelope #(.ENV_W(ENV_W), .SAMPLE_W(SAMPLE_W)) dut (
    .clk              (clk),
    .reset            (reset),
    .sample_in        (sample_in),
    .sample_valid     (sample_valid),
    .note_start       (note_start),
    .note_release     (note_release),
    .instrument       (instrument),
    .sample_out       (sample_out),
    .sample_out_valid (sample_out_valid),
    .env_active       (env_active),
    .env_done         (env_done),
    .env_level        (env_level)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Profile tables: organ, piano, flute, pluck
  int atk_t [4] = '{4096, 64, 8, 4096};
  int dec_t [4] = '{0, 2, 1, 4};
  int sus_t [4] = '{4096, 1024, 3072, 0};
  int rel_t [4] = '{4096, 4, 16, 64};
  int dsh_t [4] = '{0, 9, 10, 8};
  int rsh_t [4] = '{0, 8, 6, 5};

  // Reference model state
  int m_phase, m_level, m_prof, m_out, m_pend_val;
  bit m_done, m_pend_v, m_out_v;

  function automatic int floor_scale(input int p);
    int q;
    q = p / FULL;
    if (p < 0 && (p % FULL) != 0) q = q - 1;
    return q;
  endfunction

  function automatic int decay_step(input int lvl, input int prof, input bit is_rel);
    int s;
`ifdef ADSR_EXP_DECAY_EN
    int sh;
    sh = is_rel ? rsh_t[prof] : dsh_t[prof];
    if (sh == 0) s = lvl;
    else begin
      s = lvl / (1 << sh);
      if (s < 1) s = 1;
    end
`else
    s = is_rel ? rel_t[prof] : dec_t[prof];
`endif
    return s;
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_level = 0; m_prof = 0; m_out = 0;
    m_pend_val = 0; m_done = 0; m_pend_v = 0; m_out_v = 0;
  endtask

  // One clock of stimulus; model advanced alongside, no checking here
  task automatic drive(input bit st, input bit rl, input int inst, input bit v, input int smp);
    int step;
    note_start   = st;
    note_release = rl;
    instrument   = inst[1:0];
    sample_valid = v;
    sample_in    = smp[SAMPLE_W-1:0];

    m_out_v = m_pend_v;
    if (m_pend_v) m_out = m_pend_val;
    m_done = 0;
    if (st) begin
      m_phase = P_ATK;
      m_prof  = inst;
    end else if (rl && (m_phase == P_ATK || m_phase == P_DEC || m_phase == P_SUS)) begin
      m_phase = P_REL;
    end
    if (v) begin
      case (m_phase)
        P_ATK: begin
          m_level = m_level + atk_t[m_prof];
          if (m_level >= FULL) begin m_level = FULL; m_phase = P_DEC; end
        end
        P_DEC: begin
          step = decay_step(m_level, m_prof, 1'b0);
          if (step == 0) m_phase = P_SUS;
          else begin
            m_level = m_level - step;
            if (m_level <= sus_t[m_prof]) begin m_level = sus_t[m_prof]; m_phase = P_SUS; end
          end
        end
        P_REL: begin
          step = decay_step(m_level, m_prof, 1'b1);
          m_level = m_level - step;
          if (m_level <= 0) begin m_level = 0; m_phase = P_IDLE; m_done = 1; end
        end
        default: ;
      endcase
      m_pend_val = floor_scale(smp * m_level);
    end
    m_pend_v = v;

    @(posedge clk);
    #1;
    note_start = 1'b0; note_release = 1'b0; sample_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (sample_out !== '0) begin miscompares++; $display("FAIL rst_out: got %0d want 0", sample_out); end
    vectors++; if (sample_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_vld: got %b want 0", sample_out_valid); end
    vectors++; if (env_level !== '0) begin miscompares++; $display("FAIL rst_level: got %0d want 0", env_level); end
    vectors++; if (env_active !== 1'b0) begin miscompares++; $display("FAIL rst_active: got %b want 0", env_active); end
    vectors++; if (env_done !== 1'b0) begin miscompares++; $display("FAIL rst_done: got %b want 0", env_done); end
    reset = 1'b1;
    model_reset();
    drive(1, 0, 1, 1, int'($urandom_range(1000, 20000)));
    drive(0, 0, 1, 1, int'($urandom_range(1000, 20000)));
    vectors++; if (env_level !== 13'd128) begin miscompares++; $display("FAIL rst_pre_level: got %0d want 128", env_level); end
    #2 reset = 1'b0;
    #1;
    vectors++; if (sample_out !== '0) begin miscompares++; $display("FAIL rst_mid_out: got %0d want 0", sample_out); end
    vectors++; if (sample_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mid_vld: got %b want 0", sample_out_valid); end
    vectors++; if (env_level !== '0) begin miscompares++; $display("FAIL rst_mid_level: got %0d want 0", env_level); end
    vectors++; if (env_active !== 1'b0) begin miscompares++; $display("FAIL rst_mid_active: got %b want 0", env_active); end
    model_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0);
      vectors++; if (sample_out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_after_vld[%0d]: got %b want 0", i, sample_out_valid); end
      vectors++; if (env_level !== '0) begin miscompares++; $display("FAIL rst_after_level[%0d]: got %0d want 0", i, env_level); end
    end
  endtask

  task automatic test_organ();
    do_reset();
    drive(1, 0, 0, 0, 0);
    vectors++; if (env_active !== 1'b1) begin miscompares++; $display("FAIL organ_active: got %b want 1", env_active); end
    drive(0, 0, 0, 1, 16'sh4000);
    vectors++; if (env_level !== 13'd4096) begin miscompares++; $display("FAIL organ_level: got %0d want 4096", env_level); end
    drive(0, 0, 0, 0, 0);
    vectors++; if (sample_out_valid !== 1'b1) begin miscompares++; $display("FAIL organ_vld: got %b want 1", sample_out_valid); end
    vectors++; if (sample_out !== 16'h4000) begin miscompares++; $display("FAIL organ_out: got %h want 4000", sample_out); end
    drive(0, 0, 0, 1, 100);
    vectors++; if (env_level !== 13'd4096 || env_active !== 1'b1) begin miscompares++; $display("FAIL organ_sustain: got level %0d active %b want 4096 1", env_level, env_active); end
    drive(0, 1, 0, 0, 0);
    drive(0, 0, 0, 1, 100);
    vectors++; if (env_level !== '0) begin miscompares++; $display("FAIL organ_rel_level: got %0d want 0", env_level); end
    vectors++; if (env_done !== 1'b1) begin miscompares++; $display("FAIL organ_done: got %b want 1", env_done); end
    vectors++; if (env_active !== 1'b0) begin miscompares++; $display("FAIL organ_idle: got %b want 0", env_active); end
    drive(0, 0, 0, 0, 0);
    vectors++; if (env_done !== 1'b0) begin miscompares++; $display("FAIL organ_done_pulse: got %b want 0", env_done); end
  endtask

  task automatic test_piano();
    int want;
    do_reset();
    drive(1, 0, 1, 0, 0);
    for (int k = 1; k <= 1601; k++) begin
      drive(0, 0, 1, 1, 1000);
      drive(0, 0, 1, 0, 0);
      vectors++; if (sample_out_valid !== 1'b1 || sample_out !== 16'(m_out)) begin miscompares++; $display("FAIL piano_out[%0d]: got %0d/%b want %0d/1", k, $signed(sample_out), sample_out_valid, m_out); end
      if (k <= 64) begin
        want = (1000 * 64 * k) / 4096;
        vectors++; if ($signed(sample_out) !== 16'(want)) begin miscompares++; $display("FAIL piano_attack[%0d]: got %0d want %0d", k, $signed(sample_out), want); end
      end
      if (k == 64) begin
        vectors++; if (env_level !== 13'd4096) begin miscompares++; $display("FAIL piano_peak: got %0d want 4096", env_level); end
      end
      if (k >= 1600) begin
        vectors++; if (env_level !== 13'd1024 || sample_out !== 16'd250) begin miscompares++; $display("FAIL piano_sustain[%0d]: got level %0d out %0d want 1024 250", k, env_level, $signed(sample_out)); end
      end
      repeat (6) drive(0, 0, 1, 0, 0);
    end
  endtask

  task automatic test_negative();
    do_reset();
    drive(1, 0, 1, 0, 0);
    repeat (31) drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, -1);
    drive(0, 0, 1, 0, 0);
    vectors++; if (env_level !== 13'd2048 || sample_out !== 16'hFFFF) begin miscompares++; $display("FAIL neg_m1: got level %0d out %0d want 2048 -1", env_level, $signed(sample_out)); end
    do_reset();
    drive(1, 0, 1, 0, 0);
    repeat (31) drive(0, 0, 1, 1, 0);
    drive(0, 0, 1, 1, -3);
    drive(0, 0, 1, 0, 0);
    vectors++; if (sample_out !== 16'hFFFE) begin miscompares++; $display("FAIL neg_m3: got %0d want -2", $signed(sample_out)); end
    do_reset();
    drive(1, 0, 0, 0, 0);
    drive(0, 0, 0, 1, -32768);
    drive(0, 0, 0, 0, 0);
    vectors++; if (sample_out !== 16'h8000) begin miscompares++; $display("FAIL neg_min: got %0d want -32768", $signed(sample_out)); end
  endtask

  task automatic test_flute_release();
    do_reset();
    drive(1, 0, 2, 0, 0);
    repeat (1536) drive(0, 0, 2, 1, int'($urandom_range(0, 30000)));
    vectors++; if (env_level !== 13'd3072) begin miscompares++; $display("FAIL flute_sus: got %0d want 3072", env_level); end
    drive(0, 0, 2, 1, 5);
    vectors++; if (env_level !== 13'd3072) begin miscompares++; $display("FAIL flute_sus_hold: got %0d want 3072", env_level); end
    drive(0, 1, 2, 0, 0);
    repeat (191) drive(0, 0, 2, 1, 7);
    vectors++; if (env_level !== 13'd16 || env_done !== 1'b0) begin miscompares++; $display("FAIL flute_rel191: got level %0d done %b want 16 0", env_level, env_done); end
    drive(0, 0, 2, 1, 7);
    vectors++; if (env_level !== '0 || env_done !== 1'b1 || env_active !== 1'b0) begin miscompares++; $display("FAIL flute_rel192: got level %0d done %b active %b want 0 1 0", env_level, env_done, env_active); end
    drive(1, 0, 2, 0, 0);
    repeat (1536) drive(0, 0, 2, 1, 9);
    drive(0, 1, 2, 0, 0);
    repeat (92) drive(0, 0, 2, 1, 9);
    vectors++; if (env_level !== 13'd1600) begin miscompares++; $display("FAIL flute_1600: got %0d want 1600", env_level); end
    drive(1, 1, 2, 0, 0);
    vectors++; if (env_level !== 13'd1600 || env_active !== 1'b1) begin miscompares++; $display("FAIL flute_retrig: got level %0d active %b want 1600 1", env_level, env_active); end
    drive(0, 0, 2, 1, 9);
    vectors++; if (env_level !== 13'd1608) begin miscompares++; $display("FAIL flute_resume: got %0d want 1608", env_level); end
  endtask

  task automatic test_back_to_back();
    bit want_v;
    do_reset();
    drive(1, 0, 1, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i < 5) drive(0, 0, 1, 1, int'($urandom_range(0, 65535)) - 32768);
      else drive(0, 0, 1, 0, 0);
      want_v = (i >= 1 && i <= 5);
      vectors++; if (sample_out_valid !== want_v) begin miscompares++; $display("FAIL b2b_vld[%0d]: got %b want %b", i, sample_out_valid, want_v); end
      vectors++; if (sample_out !== 16'(m_out)) begin miscompares++; $display("FAIL b2b_out[%0d]: got %0d want %0d", i, $signed(sample_out), m_out); end
      vectors++; if (env_level !== 13'(m_level)) begin miscompares++; $display("FAIL b2b_level[%0d]: got %0d want %0d", i, env_level, m_level); end
    end
  endtask

  task automatic test_random();
    bit st, rl, v;
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      st = ($urandom_range(0, 99) < 2);
      rl = ($urandom_range(0, 99) < 2);
      v  = ($urandom_range(0, 1) == 1);
      drive(st, rl, int'($urandom_range(0, 3)), v, int'($urandom_range(0, 65535)) - 32768);
      vectors++; if (env_level !== 13'(m_level)) begin miscompares++; $display("FAIL rnd_level[%0d]: got %0d want %0d", c, env_level, m_level); end
      vectors++; if (env_active !== (m_phase != P_IDLE)) begin miscompares++; $display("FAIL rnd_active[%0d]: got %b want %b", c, env_active, m_phase != P_IDLE); end
      vectors++; if (env_done !== m_done) begin miscompares++; $display("FAIL rnd_done[%0d]: got %b want %b", c, env_done, m_done); end
      vectors++; if (sample_out_valid !== m_out_v) begin miscompares++; $display("FAIL rnd_vld[%0d]: got %b want %b", c, sample_out_valid, m_out_v); end
      vectors++; if (sample_out !== 16'(m_out)) begin miscompares++; $display("FAIL rnd_out[%0d]: got %0d want %0d", c, $signed(sample_out), m_out); end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_organ();
    test_piano();
    test_negative();
    test_flute_release();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
